// File: rtl/store_buffer.sv
// Store buffer between a single-cycle datapath and a handshaked data memory.
// Stores are queued in a FIFO, forwarded to later loads, and drained in the background.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic        memread,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        stall,
    output logic        empty,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WR    = 2'd1;
    localparam logic [1:0] S_RD    = 2'd2;
    localparam logic [1:0] S_LDONE = 2'd3;

    logic [29:0]   ent_addr_q [DEPTH];
    logic [31:0]   ent_data_q [DEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic [31:0]   ld_q, ld_d;

    logic          full;
    logic          ld_en;
    logic          do_enq;
    logic          do_pop;
    logic          hit;
    logic [31:0]   hit_data;
    logic [PW-1:0] slot;
    logic          miss;

    // Only the word address is meaningful; the byte offset is dropped.
    logic          unused_addr_lo;
    assign unused_addr_lo = ^addr[1:0];

    assign full   = (count_q == CW'(DEPTH));
    assign ld_en  = memread & ~memwrite;
    assign do_enq = memwrite & ~full;

    // Scan oldest to newest so the last match wins (newest store forwards).
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        slot     = head_q;
        for (int k = 0; k < DEPTH; k++) begin
            slot = head_q + PW'(k);
            if ((CW'(k) < count_q) && (ent_addr_q[slot] == addr[31:2])) begin
                hit      = 1'b1;
                hit_data = ent_data_q[slot];
            end
        end
    end

    // In LDONE the load register answers, so the same load is not a miss again.
    assign miss  = ld_en & ~hit & (state_q != S_LDONE);
    assign stall = (memwrite & full) | miss;

    always_comb begin
        readdata = '0;
        if (ld_en) begin
            if (state_q == S_LDONE) begin
                readdata = ld_q;
            end else if (hit) begin
                readdata = hit_data;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        ld_d        = ld_q;
        do_pop      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (miss) begin
                    state_d    = S_RD;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {addr[31:2], 2'b00};
                end else if (count_q != '0) begin
                    state_d     = S_WR;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {ent_addr_q[head_q], 2'b00};
                    mem_wdata_d = ent_data_q[head_q];
                end
            end
            S_WR: begin
                if (mem_ack) begin
                    do_pop    = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            S_RD: begin
                if (mem_ack) begin
                    ld_d      = mem_rdata;
                    mem_req_d = 1'b0;
                    state_d   = S_LDONE;
                end
            end
            S_LDONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        head_d  = do_pop ? head_q + PW'(1) : head_q;
        tail_d  = do_enq ? tail_q + PW'(1) : tail_q;
        case ({do_enq, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            state_q     <= S_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ld_q        <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ld_q        <= ld_d;
        end
    end

    // Entry storage needs no reset: validity comes from head/count.
    always_ff @(posedge clk) begin
        if (do_enq) begin
            ent_addr_q[tail_q] <= addr[31:2];
            ent_data_q[tail_q] <= writedata;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign empty     = (count_q == '0) && (state_q == S_IDLE);

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a scoreboard of expected drains and load results.
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic        memread;
    logic [31:0] addr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        stall;
    logic        empty;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_wa[$];
    logic [31:0] exp_wd[$];
    logic [31:0] obs_wa[$];
    logic [31:0] obs_wd[$];
    logic [31:0] exp_ld[$];

    bit wr_hold = 1'b0;
    bit rd_hold = 1'b0;
    int wr_wait = 0;
    int rd_wait = 0;
    int wr_seen = 0;
    int age     = 0;

    store_buffer #(.DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .memread   (memread),
        .addr      (addr),
        .writedata (writedata),
        .readdata  (readdata),
        .stall     (stall),
        .empty     (empty),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_model(input logic [31:0] a);
        return (a == 32'h10020000) ? 32'hDEADBEEF : (a ^ 32'h5A5A5A5A);
    endfunction

    // Memory: acks after a programmable number of request cycles, logs completed writes.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req === 1'b1 && reset === 1'b0) begin
                if (mem_we === 1'b1) wr_seen++;
                if (mem_we === 1'b1 ? (!wr_hold && age >= wr_wait)
                                    : (!rd_hold && age >= rd_wait)) begin
                    mem_ack = 1'b1;
                    age     = 0;
                    if (mem_we === 1'b1) begin
                        obs_wa.push_back(mem_addr);
                        obs_wd.push_back(mem_wdata);
                    end else begin
                        mem_rdata = rd_model(mem_addr);
                    end
                end else begin
                    age++;
                end
            end else begin
                age = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input string tag);
        memwrite  = 1'b1;
        addr      = a;
        writedata = d;
        @(negedge clk);
        chk(tag, 32'(stall), 32'd0);
        exp_wa.push_back({a[31:2], 2'b00});
        exp_wd.push_back(d);
        tick();
        memwrite = 1'b0;
    endtask

    task automatic wait_req(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc && !ok; i++) begin
            @(negedge clk);
            ok = (mem_req === 1'b1);
        end
    endtask

    task automatic wait_empty(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc && !ok; i++) begin
            @(negedge clk);
            ok = (empty === 1'b1);
        end
    endtask

    task automatic check_drain(input string tag);
        chk({tag, "_cnt"}, 32'(obs_wa.size()), 32'(exp_wa.size()));
        while (obs_wa.size() > 0 && exp_wa.size() > 0) begin
            chk({tag, "_addr"}, obs_wa.pop_front(), exp_wa.pop_front());
            chk({tag, "_data"}, obs_wd.pop_front(), exp_wd.pop_front());
        end
        obs_wa.delete();
        obs_wd.delete();
        exp_wa.delete();
        exp_wd.delete();
    endtask

    initial begin
        bit ok;
        int n;
        int rd_idx;
        int seen_snap;

        reset     = 1'b1;
        memwrite  = 1'b0;
        memread   = 1'b0;
        addr      = '0;
        writedata = '0;
        repeat (2) @(negedge clk);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_readdata", readdata, 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Single store and drain
        do_store(32'h10010000, 32'h11111111, "t1_stall");
        wait_req(6, ok);
        chk("t1_req_seen", 32'(ok), 32'd1);
        chk("t1_mem_we", 32'(mem_we), 32'd1);
        chk("t1_mem_addr", mem_addr, 32'h10010000);
        chk("t1_mem_wdata", mem_wdata, 32'h11111111);
        wait_empty(10, ok);
        chk("t1_empty", 32'(ok), 32'd1);
        check_drain("t1_drain");
        tick();

        // Fill the buffer with acks held, then a fifth store stalls until a pop
        wr_hold = 1'b1;
        for (int i = 0; i < 4; i++)
            do_store(32'h10010000 + 32'(i * 4), 32'hA0A00000 + 32'(i), "t2_stall");
        memwrite  = 1'b1;
        addr      = 32'h10010010;
        writedata = 32'hA0A00004;
        @(negedge clk);
        chk("t2_full_stall", 32'(stall), 32'd1);
        tick();
        @(negedge clk);
        chk("t2_full_stall2", 32'(stall), 32'd1);
        tick();
        wr_hold = 1'b0;
        n = 0;
        @(negedge clk);
        while (stall === 1'b1 && n < 10) begin
            n++;
            @(negedge clk);
        end
        chk("t2_stall_cycles_after_release", 32'(n), 32'd1);
        exp_wa.push_back(32'h10010010);
        exp_wd.push_back(32'hA0A00004);
        tick();
        memwrite = 1'b0;
        wait_empty(40, ok);
        chk("t2_empty", 32'(ok), 32'd1);
        check_drain("t2_drain");
        tick();

        // Forwarding: newest of two stores to the same word
        wr_hold = 1'b1;
        do_store(32'h10010008, 32'hAAAA0000, "t3_stall");
        do_store(32'h10010008, 32'hBBBB0000, "t3_stall");
        memread = 1'b1;
        addr    = 32'h1001000A;
        exp_ld.push_back(32'hBBBB0000);
        @(negedge clk);
        chk("t3_hit_stall", 32'(stall), 32'd0);
        chk("t3_hit_data", readdata, exp_ld.pop_front());
        tick();
        memread = 1'b0;
        @(negedge clk);
        chk("t3_readdata_idle", readdata, 32'd0);
        tick();
        wr_hold = 1'b0;
        wait_empty(20, ok);
        chk("t3_empty", 32'(ok), 32'd1);
        check_drain("t3_drain");
        tick();

        // Load miss with immediate ack; read goes ahead of a queued write
        do_store(32'h10030000, 32'h5555AAAA, "t4_stall");
        memread = 1'b1;
        addr    = 32'h10020000;
        exp_ld.push_back(32'hDEADBEEF);
        @(negedge clk);
        chk("t4_stall_c0", 32'(stall), 32'd1);
        tick();
        @(negedge clk);
        chk("t4_stall_c1", 32'(stall), 32'd1);
        chk("t4_rd_req", 32'(mem_req), 32'd1);
        chk("t4_rd_we", 32'(mem_we), 32'd0);
        chk("t4_rd_addr", mem_addr, 32'h10020000);
        tick();
        @(negedge clk);
        chk("t4_ldone_stall", 32'(stall), 32'd0);
        chk("t4_ldone_data", readdata, exp_ld.pop_front());
        tick();
        memread = 1'b0;
        wait_empty(20, ok);
        chk("t4_empty", 32'(ok), 32'd1);
        check_drain("t4_drain");
        tick();

        // Load miss behind an in-flight write whose ack is delayed
        wr_wait = 3;
        do_store(32'h10040000, 32'h77777777, "t5_stall");
        wait_req(6, ok);
        chk("t5_wr_seen", 32'(ok), 32'd1);
        tick();
        memread = 1'b1;
        addr    = 32'h10050000;
        exp_ld.push_back(32'h4A5F5A5A);
        n      = 0;
        rd_idx = -1;
        @(negedge clk);
        while (stall === 1'b1 && n < 20) begin
            if (mem_req === 1'b1 && mem_we === 1'b0 && rd_idx < 0) rd_idx = n;
            n++;
            @(negedge clk);
        end
        chk("t5_stall_cycles", 32'(n), 32'd5);
        chk("t5_rd_issue_cycle", 32'(rd_idx), 32'd4);
        chk("t5_ldone_data", readdata, exp_ld.pop_front());
        tick();
        memread = 1'b0;
        wr_wait = 0;
        wait_empty(20, ok);
        chk("t5_empty", 32'(ok), 32'd1);
        check_drain("t5_drain");
        tick();

        // Reset while a read is outstanding and three stores are buffered
        wr_hold = 1'b1;
        rd_hold = 1'b1;
        for (int i = 0; i < 4; i++)
            do_store(32'h10070000 + 32'(i * 4), 32'hC0000000 + 32'(i), "t6_stall");
        wr_hold = 1'b0;
        tick();
        wr_hold = 1'b1;
        memread = 1'b1;
        addr    = 32'h10060000;
        @(negedge clk);
        chk("t6_miss_stall", 32'(stall), 32'd1);
        tick();
        @(negedge clk);
        chk("t6_rd_req", 32'(mem_req), 32'd1);
        chk("t6_rd_we", 32'(mem_we), 32'd0);
        tick();
        reset   = 1'b1;
        memread = 1'b0;
        #1;
        chk("t6_rst_req", 32'(mem_req), 32'd0);
        chk("t6_rst_empty", 32'(empty), 32'd1);
        chk("t6_rst_stall", 32'(stall), 32'd0);
        seen_snap = wr_seen;
        tick();
        reset   = 1'b0;
        rd_hold = 1'b0;
        wr_hold = 1'b0;
        repeat (10) @(negedge clk);
        chk("t6_no_writes_after", 32'(wr_seen), 32'(seen_snap));
        chk("t6_empty_after", 32'(empty), 32'd1);
        chk("t6_drained_cnt", 32'(obs_wa.size()), 32'd1);
        if (obs_wa.size() > 0) begin
            chk("t6_drained_addr", obs_wa[0], 32'h10070000);
            chk("t6_drained_data", obs_wd[0], 32'hC0000000);
        end
        obs_wa.delete();
        obs_wd.delete();
        exp_wa.delete();
        exp_wd.delete();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
